mlp_infer_ctrl: RTL and testbench

MLP_INFER_CTRL -- requirements
Module: mlp_infer_ctrl

---
 rtl/mlp_ctrl_pkg.sv | 23 ++
 rtl/mlp_infer_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mlp_infer_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_ctrl_pkg.sv
// Shared definitions for the MLP inference controller: FSM state encoding
// and default frame/latency/address geometry.
package mlp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ZFILL = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int DEF_N_PIX      = 784;
  localparam int DEF_LAT_CYCLES = 864;
  localparam int DEF_ADDR_W     = 10;

  // Pixel beats are only taken while a frame can still be loaded or drained.
  function automatic logic accepts_beats(input state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/mlp_infer_ctrl.sv
// Frame sequencer for an MLP digit classifier: loads one frame of pixels into an
// external buffer, holds the datapath in reset between frames, and returns one prediction.
module mlp_infer_ctrl
  import mlp_ctrl_pkg::*;
#(
  parameter int N_PIX      = DEF_N_PIX,
  parameter int LAT_CYCLES = DEF_LAT_CYCLES,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [31:0]       pix_wdata,
  output logic              nn_rstn,
  input  logic [3:0]        pred_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [3:0]        m_pred,
  output logic              short_frame,
  output logic              long_frame,
  output logic [15:0]       frame_cnt
);

  localparam int FILL_W = ADDR_W + 1;
  localparam int RUN_W  = $clog2(LAT_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIX - 1);
  localparam logic [FILL_W-1:0] FILL_END = FILL_W'(N_PIX);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(LAT_CYCLES - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   idx, idx_next;
  logic [FILL_W-1:0]   fill, fill_next;
  logic [RUN_W-1:0]    run_cnt, run_cnt_next;
  logic                we_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [31:0]         wdata_next;
  logic                short_next, long_next;
  logic                cap_pred, frame_done;
  logic                accept;
  logic [ADDR_W-1:0]   cur_idx;

  assign s_ready = accepts_beats(state);
  assign accept  = s_valid && s_ready;
  assign cur_idx = (state == ST_IDLE) ? '0 : idx;

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    fill_next    = fill;
    run_cnt_next = run_cnt;
    we_next      = 1'b0;
    addr_next    = pix_addr;
    wdata_next   = pix_wdata;
    short_next   = short_frame;
    long_next    = long_frame;
    cap_pred     = 1'b0;
    frame_done   = 1'b0;

    case (state)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = cur_idx;
          wdata_next = s_data;
          if (state == ST_IDLE) begin
            short_next = 1'b0;
            long_next  = 1'b0;
          end
          // A complete frame still passes through ZFILL with nothing left to
          // fill, so its final registered write lands before the datapath starts.
          if (cur_idx == LAST_IDX) begin
            if (s_last) begin
              state_next = ST_ZFILL;
              fill_next  = FILL_END;
            end else begin
              state_next = ST_DRAIN;
            end
          end else if (s_last) begin
            state_next = ST_ZFILL;
            short_next = 1'b1;
            fill_next  = FILL_W'(cur_idx) + FILL_W'(1);
          end else begin
            state_next = ST_LOAD;
            idx_next   = cur_idx + ADDR_W'(1);
          end
        end
      end

      ST_ZFILL: begin
        if (fill == FILL_END) begin
          state_next   = ST_RUN;
          run_cnt_next = '0;
        end else begin
          we_next    = 1'b1;
          addr_next  = fill[ADDR_W-1:0];
          wdata_next = '0;
          fill_next  = fill + FILL_W'(1);
        end
      end

      ST_DRAIN: begin
        if (accept) begin
          long_next = 1'b1;
          if (s_last) begin
            state_next   = ST_RUN;
            run_cnt_next = '0;
          end
        end
      end

      ST_RUN: begin
        if (run_cnt == RUN_LAST) begin
          cap_pred   = 1'b1;
          state_next = ST_DONE;
        end else begin
          run_cnt_next = run_cnt + RUN_W'(1);
        end
      end

      ST_DONE: begin
        if (m_ready) begin
          frame_done = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // nn_rstn and m_valid are decoded from the next state so they track the
  // state register exactly while still coming straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      idx         <= '0;
      fill        <= '0;
      run_cnt     <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_wdata   <= '0;
      nn_rstn     <= 1'b0;
      m_valid     <= 1'b0;
      m_pred      <= '0;
      short_frame <= 1'b0;
      long_frame  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      fill        <= fill_next;
      run_cnt     <= run_cnt_next;
      pix_we      <= we_next;
      pix_addr    <= addr_next;
      pix_wdata   <= wdata_next;
      nn_rstn     <= (state_next == ST_RUN);
      m_valid     <= (state_next == ST_DONE);
      short_frame <= short_next;
      long_frame  <= long_next;
      if (cap_pred) begin
        m_pred <= pred_in;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Self-checking bench for mlp_infer_ctrl: table of frame shapes plus random
// lengths/gaps, checked against a frame-level model of the pixel buffer contents.
module tb_mlp_infer_ctrl;
  import mlp_ctrl_pkg::*;

  localparam int N_PIX  = DEF_N_PIX;
  localparam int LAT    = DEF_LAT_CYCLES;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int N_VEC  = 10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_data = '0;
  logic              s_last = 1'b0;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [31:0]       pix_wdata;
  logic              nn_rstn;
  logic [3:0]        pred_in = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [3:0]        m_pred;
  logic              short_frame;
  logic              long_frame;
  logic [15:0]       frame_cnt;

  always #5 clk = ~clk;

  mlp_infer_ctrl #(.N_PIX(N_PIX), .LAT_CYCLES(LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_wdata(pix_wdata),
    .nn_rstn(nn_rstn), .pred_in(pred_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_pred(m_pred),
    .short_frame(short_frame), .long_frame(long_frame), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int         nbeats;
    int         gap;
    logic [3:0] pred;
    int         hold;
    bit         exp_short;
    bit         exp_long;
  } vec_t;

  vec_t tbl[N_VEC];

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  // Observed pixel-buffer writes and datapath release windows.
  int                cyc = 0;
  int                last_we_cyc = -1;
  int                run_len = 0;
  int                order_bad = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                run_q[$];
  logic [31:0]       beat_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pix_we) begin
      wr_addr_q.push_back(pix_addr);
      wr_data_q.push_back(pix_wdata);
      last_we_cyc = cyc;
    end
    if (nn_rstn) begin
      if (run_len == 0 && cyc <= last_we_cyc) order_bad = order_bad + 1;
      run_len = run_len + 1;
    end else if (run_len != 0) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
  end

  // The datapath model only presents the true answer in the final cycle of
  // its release window, so a mistimed capture returns the wrong digit.
  logic [3:0] cur_pred = '0;
  int         pcnt = 0;
  always @(negedge clk) begin
    if (nn_rstn) pcnt = pcnt + 1;
    else pcnt = 0;
    pred_in = (pcnt == LAT) ? cur_pred : (cur_pred ^ 4'hF);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input int nb, input int gap, input logic [3:0] pred, input int hold);
    vec_t v;
    v.nbeats    = nb;
    v.gap       = gap;
    v.pred      = pred;
    v.hold      = hold;
    v.exp_short = (nb < N_PIX);
    v.exp_long  = (nb > N_PIX);
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_pix_we"}, pix_we, 0);
    chk({tag, "_pix_addr"}, pix_addr, 0);
    chk({tag, "_pix_wdata"}, pix_wdata, 0);
    chk({tag, "_nn_rstn"}, nn_rstn, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_pred"}, m_pred, 0);
    chk({tag, "_short"}, short_frame, 0);
    chk({tag, "_long"}, long_frame, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
  endtask

  task automatic send_frame(input int nbeats, input int gap);
    int guard;
    beat_q.delete();
    for (int j = 0; j < nbeats; j++) begin
      logic [31:0] d;
      d = $urandom;
      guard = 0;
      forever begin
        tick();
        guard = guard + 1;
        if (guard > 5000) break;
        if (gap != 0 && $urandom_range(99) < gap) begin
          s_valid = 1'b0;
          continue;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = (j == nbeats - 1);
        if (s_ready) break;
      end
      if (guard > 5000) begin
        chk("beat_accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      beat_q.push_back(d);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int w0, r0, ob0, n, bad;
    logic [31:0] exp_d;
    cur_pred = v.pred;
    w0  = wr_addr_q.size();
    r0  = run_q.size();
    ob0 = order_bad;
    send_frame(v.nbeats, v.gap);
    n = 0;
    while (!m_valid && n < 4000) begin
      tick();
      n = n + 1;
    end
    chk("m_valid_rise", m_valid, 1);
    if (!m_valid) return;
    chk("m_pred", m_pred, v.pred);
    chk("short_frame", short_frame, v.exp_short);
    chk("long_frame", long_frame, v.exp_long);
    chk("wr_count", wr_addr_q.size() - w0, N_PIX);
    // Buffer image expected: accepted beats in order, zero past a short frame's end.
    bad = 0;
    for (int a = 0; a < N_PIX && (w0 + a) < wr_addr_q.size(); a++) begin
      exp_d = (a < beat_q.size()) ? beat_q[a] : 32'd0;
      if (wr_addr_q[w0 + a] != ADDR_W'(a) || wr_data_q[w0 + a] != exp_d) bad = bad + 1;
    end
    chk("wr_content_errs", bad, 0);
    chk("run_windows", run_q.size() - r0, 1);
    if (run_q.size() > r0) chk("run_len", run_q[r0], LAT);
    chk("run_after_last_write", order_bad - ob0, 0);
    chk("done_s_ready", s_ready, 0);
    bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      if (!m_valid || m_pred != v.pred || s_ready) bad = bad + 1;
    end
    if (v.hold > 0) chk("done_hold", bad, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk("m_valid_fall", m_valid, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
    $display("frame %0d: beats=%0d gap=%0d%% pred=%0d short=%0b long=%0b frame_cnt=%0d",
             id, v.nbeats, v.gap, v.pred, short_frame, long_frame, frame_cnt);
  endtask

  initial begin
    int n, bad;
    tbl[0] = mk(784, 0, 4'd7, 0);
    tbl[1] = mk(100, 0, 4'd3, 0);
    tbl[2] = mk(790, 0, 4'd9, 0);
    tbl[3] = mk(784, 0, 4'd5, 50);
    tbl[4] = mk(784, 50, 4'd2, 3);
    tbl[5] = mk(1, 50, 4'd15, 0);
    tbl[6] = mk(785, 30, 4'd8, 1);
    tbl[7] = mk(783, 20, 4'd1, 0);
    tbl[8] = mk(int'($urandom_range(1, 900)), 50, 4'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
    tbl[9] = mk(int'($urandom_range(700, 850)), 25, 4'($urandom_range(0, 15)), 0);

    tick();
    tick();
    check_reset("init");
    rstn = 1'b1;
    tick();

    for (int i = 0; i < N_VEC; i++) run_frame(tbl[i], i);

    // Reset in RUN cycle 400: frame abandoned, no result, then a clean frame.
    cur_pred = 4'd6;
    send_frame(N_PIX, 0);
    n = 0;
    while (!nn_rstn && n < 100) begin
      tick();
      n = n + 1;
    end
    chk("run_start", nn_rstn, 1);
    for (int i = 0; i < 399; i++) tick();
    rstn = 1'b0;
    #1;
    check_reset("async_rst");
    tick();
    tick();
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (m_valid || nn_rstn) bad = bad + 1;
    end
    chk("no_result_after_rst", bad, 0);
    exp_cnt = 0;
    run_frame(tbl[0], N_VEC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
